log_line_arbiter: RTL and testbench

LOG_LINE_ARBITER -- requirements
Module: log_line_arbiter

---
 rtl/log_arb_pkg.sv | 21 ++
 rtl/log_line_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_log_line_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/log_arb_pkg.sv
// -----------------------------------------------------------------------------
// log_arb_pkg
// Shared definitions for the two-source log line arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / BUSY / ABORT)
//   CH_START    : '^' opens a line and is the only character that wins a grant
//   CH_END      : '#' closes a line
//   CH_RESYNC   : 8'h0A, emitted on an aborted line so the checker can resync
// -----------------------------------------------------------------------------
package log_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam logic [7:0] CH_START  = 8'h5E;  // '^'
    localparam logic [7:0] CH_END    = 8'h23;  // '#'
    localparam logic [7:0] CH_RESYNC = 8'h0A;

endpackage

// File: rtl/log_line_arbiter.sv
// -----------------------------------------------------------------------------
// log_line_arbiter
// Merges character streams from two log sources onto one line checker, one
// complete line at a time. A source wins the line by presenting '^'; ties are
// broken by a round-robin pointer that flips after every finished or aborted
// line. The granted source owns the output until it sends '#', exceeds
// MAX_LINE characters, or stays idle for STALL_MAX cycles. On an abort a
// single 8'h0A resync character is emitted with line_abort.
//
// Parameters
//   MAX_LINE  : most characters forwarded per line, '^' and '#' included
//   STALL_MAX : consecutive idle cycles of the granted source before abort
//
// Ports
//   clk                     clock, rising edge
//   reset                   synchronous, active-high
//   s0_char/s0_valid        source 0 character stream
//   s0_ready                source 0 character consumed this cycle (comb)
//   s1_char/s1_valid/s1_ready  same for source 1
//   out_char/out_valid      registered forwarded character
//   out_src                 source index owning the current line
//   line_done               pulse coincident with '#' on out_char
//   line_abort              pulse coincident with 8'h0A on out_char
//   busy                    high while a line is open or being aborted
// -----------------------------------------------------------------------------
module log_line_arbiter
    import log_arb_pkg::*;
#(
    parameter int MAX_LINE  = 64,
    parameter int STALL_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s0_char,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_char,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] out_char,
    output logic       out_valid,
    output logic       out_src,
    output logic       line_done,
    output logic       line_abort,
    output logic       busy
);

    localparam int LW = $clog2(MAX_LINE + 1);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [LW-1:0] LINE_LIMIT  = LW'(MAX_LINE);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_MAX);

    arb_state_e    state_q, state_d;
    logic          rr_q, rr_d;
    logic          src_q, src_d;
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]    out_char_q, out_char_d;
    logic          out_valid_q, out_valid_d;
    logic          line_done_q, line_done_d;
    logic          line_abort_q, line_abort_d;

    // Arbitration inputs: only a '^' makes a source eligible for a grant.
    logic elig0, elig1;
    logic win0, win1;
    assign elig0 = s0_valid && (s0_char == CH_START);
    assign elig1 = s1_valid && (s1_char == CH_START);
    assign win0  = elig0 && (!elig1 || !rr_q);
    assign win1  = elig1 && (!elig0 ||  rr_q);

    // Granted source's stream, as seen while a line is open.
    logic       g_valid;
    logic [7:0] g_char;
    assign g_valid = src_q ? s1_valid : s0_valid;
    assign g_char  = src_q ? s1_char  : s0_char;

    logic [LW-1:0] line_cnt_inc;
    logic [SW-1:0] stall_cnt_inc;
    assign line_cnt_inc  = line_cnt_q + 1'b1;
    assign stall_cnt_inc = stall_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        src_d        = src_q;
        line_cnt_d   = line_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        out_char_d   = 8'h00;
        out_valid_d  = 1'b0;
        line_done_d  = 1'b0;
        line_abort_d = 1'b0;
        s0_ready     = 1'b0;
        s1_ready     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Anything that is not a '^' is drained and dropped; an
                // eligible source that loses the tie keeps its '^' pending.
                s0_ready = !elig0 || win0;
                s1_ready = !elig1 || win1;
                if (win0 || win1) begin
                    src_d       = win1;
                    out_char_d  = CH_START;
                    out_valid_d = 1'b1;
                    line_cnt_d  = LW'(1);
                    stall_cnt_d = '0;
                    // A one-character limit is already exhausted by the '^'.
                    state_d     = (MAX_LINE == 1) ? ST_ABORT : ST_BUSY;
                end
            end

            ST_BUSY: begin
                s0_ready = !src_q;
                s1_ready =  src_q;
                if (g_valid) begin
                    out_char_d  = g_char;
                    out_valid_d = 1'b1;
                    line_cnt_d  = line_cnt_inc;
                    stall_cnt_d = '0;
                    // '#' is tested first so a '#' landing exactly on the
                    // limit completes the line instead of aborting it.
                    if (g_char == CH_END) begin
                        line_done_d = 1'b1;
                        rr_d        = ~src_q;
                        state_d     = ST_IDLE;
                    end else if (line_cnt_inc == LINE_LIMIT) begin
                        state_d = ST_ABORT;
                    end
                end else begin
                    stall_cnt_d = stall_cnt_inc;
                    // Compare the incremented value so the abort cycle
                    // directly follows the last tolerated idle cycle.
                    if (stall_cnt_inc == STALL_LIMIT) begin
                        state_d = ST_ABORT;
                    end
                end
            end

            ST_ABORT: begin
                out_char_d   = CH_RESYNC;
                out_valid_d  = 1'b1;
                line_abort_d = 1'b1;
                rr_d         = ~src_q;
                line_cnt_d   = '0;
                stall_cnt_d  = '0;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Readys are combinational, so hold them low while reset is asserted
        // rather than waiting for the state register to clear.
        if (reset) begin
            s0_ready = 1'b0;
            s1_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            src_q        <= 1'b0;
            line_cnt_q   <= '0;
            stall_cnt_q  <= '0;
            out_char_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            line_done_q  <= 1'b0;
            line_abort_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            src_q        <= src_d;
            line_cnt_q   <= line_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            out_char_q   <= out_char_d;
            out_valid_q  <= out_valid_d;
            line_done_q  <= line_done_d;
            line_abort_q <= line_abort_d;
        end
    end

    assign out_char   = out_char_q;
    assign out_valid  = out_valid_q;
    assign out_src    = src_q;
    assign line_done  = line_done_q;
    assign line_abort = line_abort_q;
    assign busy       = !reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_log_line_arbiter.sv
// -----------------------------------------------------------------------------
// tb_log_line_arbiter
// Directed bench for log_line_arbiter. Two instances share the same stimulus:
// dut uses the default limits, dut8 uses MAX_LINE=8 for the line-length cases.
// Inputs change 1 ns after the rising edge; readys are checked 1 ns later and
// registered outputs 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_log_line_arbiter;

    localparam logic [7:0] CH_START  = 8'h5E;
    localparam logic [7:0] CH_END    = 8'h23;
    localparam logic [7:0] CH_RESYNC = 8'h0A;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] s0_char, s1_char;
    logic       s0_valid, s1_valid;

    logic       s0_ready, s1_ready;
    logic [7:0] out_char;
    logic       out_valid, out_src, line_done, line_abort, busy;

    logic       b_s0_ready, b_s1_ready;
    logic [7:0] b_out_char;
    logic       b_out_valid, b_out_src, b_line_done, b_line_abort, b_busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    log_line_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .s0_char   (s0_char),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s1_char   (s1_char),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_src   (out_src),
        .line_done (line_done),
        .line_abort(line_abort),
        .busy      (busy)
    );

    log_line_arbiter #(.MAX_LINE(8), .STALL_MAX(16)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .s0_char   (s0_char),
        .s0_valid  (s0_valid),
        .s0_ready  (b_s0_ready),
        .s1_char   (s1_char),
        .s1_valid  (s1_valid),
        .s1_ready  (b_s1_ready),
        .out_char  (b_out_char),
        .out_valid (b_out_valid),
        .out_src   (b_out_src),
        .line_done (b_line_done),
        .line_abort(b_line_abort),
        .busy      (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic drive(input logic [7:0] c0, input logic v0, input logic [7:0] c1, input logic v1);
        s0_char  = c0;
        s0_valid = v0;
        s1_char  = c1;
        s1_valid = v1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        step();
        reset = 1'b0;
    endtask

    string line;

    initial begin
        reset = 1'b1;
        drive(CH_START, 1'b1, CH_START, 1'b1);
        #1;

        // ---------------- reset state -----------------
        step();
        check("rst_s0_ready", s0_ready, 0);
        check("rst_s1_ready", s1_ready, 0);
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_out_src", out_src, 0);
        check("rst_busy", busy, 0);
        check("rst_done", line_done, 0);
        check("rst_abort", line_abort, 0);
        reset = 1'b0;
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();

        // ---------------- single source full line -----------------
        line = "^10@00003000: $1 <= 0000000a#";
        for (int i = 0; i < line.len(); i++) begin
            drive(line[i], 1'b1, 8'h00, 1'b0);
            #1;
            check("t1_s0_ready", s0_ready, 1);
            step();
            check("t1_out_char", out_char, line[i]);
            check("t1_out_valid", out_valid, 1);
            check("t1_out_src", out_src, 0);
            check("t1_line_done", line_done, (i == line.len() - 1) ? 1 : 0);
        end
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        check("t1_idle_valid", out_valid, 0);
        check("t1_idle_done", line_done, 0);
        check("t1_idle_busy", busy, 0);

        // ---------------- simultaneous '^' -----------------
        do_reset();
        drive(CH_START, 1'b1, CH_START, 1'b1);
        #1;
        check("t2_s0_ready", s0_ready, 1);
        check("t2_s1_ready", s1_ready, 0);
        step();
        check("t2_grant_char", out_char, CH_START);
        check("t2_grant_src", out_src, 0);
        line = "ab#";
        for (int i = 0; i < line.len(); i++) begin
            drive(line[i], 1'b1, CH_START, 1'b1);
            #1;
            check("t2_s1_held", s1_ready, 0);
            step();
            check("t2_out_char", out_char, line[i]);
            check("t2_out_src", out_src, 0);
        end
        check("t2_done", line_done, 1);
        drive(8'h00, 1'b0, CH_START, 1'b1);
        #1;
        check("t2_s1_ready_after", s1_ready, 1);
        step();
        check("t2_s1_grant_char", out_char, CH_START);
        check("t2_s1_grant_src", out_src, 1);
        check("t2_s1_busy", busy, 1);
        drive(8'h00, 1'b0, CH_END, 1'b1);
        step();
        check("t2_s1_done", line_done, 1);
        drive(8'h00, 1'b0, 8'h00, 1'b0);

        // ---------------- drop non-'^' while idle -----------------
        do_reset();
        line = "xy";
        for (int i = 0; i < line.len(); i++) begin
            drive(8'h00, 1'b0, line[i], 1'b1);
            #1;
            check("t3_drop_ready", s1_ready, 1);
            step();
            check("t3_drop_valid", out_valid, 0);
        end
        drive(8'h00, 1'b0, CH_START, 1'b1);
        step();
        check("t3_start_valid", out_valid, 1);
        check("t3_start_char", out_char, CH_START);
        check("t3_start_src", out_src, 1);
        drive(8'h00, 1'b0, 8'h00, 1'b0);

        // ---------------- stall abort -----------------
        do_reset();
        drive(CH_START, 1'b1, 8'h00, 1'b0);
        step();
        drive("A", 1'b1, 8'h00, 1'b0);
        step();
        check("t4_char_a", out_char, "A");
        drive(8'h00, 1'b0, CH_START, 1'b1);
        for (int i = 0; i < 16; i++) begin
            #1;
            check("t4_stall_s1_ready", s1_ready, 0);
            step();
            check("t4_stall_valid", out_valid, 0);
            check("t4_stall_abort", line_abort, 0);
        end
        check("t4_abort_busy", busy, 1);
        check("t4_abort_s0_ready", s0_ready, 0);
        check("t4_abort_s1_ready", s1_ready, 0);
        step();
        check("t4_resync_char", out_char, CH_RESYNC);
        check("t4_resync_valid", out_valid, 1);
        check("t4_line_abort", line_abort, 1);
        check("t4_no_done", line_done, 0);
        check("t4_s1_ready", s1_ready, 1);
        step();
        check("t4_s1_grant_char", out_char, CH_START);
        check("t4_s1_grant_src", out_src, 1);
        drive(8'h00, 1'b0, 8'h00, 1'b0);

        // ---------------- MAX_LINE=8 length abort, then exact line -----------------
        do_reset();
        line = "^12345678";
        for (int i = 0; i < 8; i++) begin
            drive(line[i], 1'b1, 8'h00, 1'b0);
            step();
            check("t5_out_char", b_out_char, line[i]);
            check("t5_out_abort", b_line_abort, 0);
        end
        drive(line[8], 1'b1, 8'h00, 1'b0);
        #1;
        check("t5_abort_ready", b_s0_ready, 0);
        step();
        check("t5_resync_char", b_out_char, CH_RESYNC);
        check("t5_line_abort", b_line_abort, 1);
        check("t5_no_done", b_line_done, 0);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        line = "^123456#";
        for (int i = 0; i < line.len(); i++) begin
            drive(line[i], 1'b1, 8'h00, 1'b0);
            step();
            check("t5x_out_char", b_out_char, line[i]);
        end
        check("t5x_done", b_line_done, 1);
        check("t5x_no_abort", b_line_abort, 0);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();
        check("t5x_after_valid", b_out_valid, 0);
        check("t5x_after_abort", b_line_abort, 0);
        check("t5x_after_busy", b_busy, 0);

        // ---------------- reset mid-line -----------------
        do_reset();
        drive(CH_START, 1'b1, 8'h00, 1'b0);
        step();
        drive(CH_END, 1'b1, 8'h00, 1'b0);
        step();
        check("t6_first_done", line_done, 1);
        drive(8'h00, 1'b0, CH_START, 1'b1);
        step();
        drive(8'h00, 1'b0, "a", 1'b1);
        step();
        check("t6_mid_src", out_src, 1);
        check("t6_mid_busy", busy, 1);
        reset = 1'b1;
        drive(8'h00, 1'b0, "b", 1'b1);
        step();
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", line_done, 0);
        check("t6_rst_abort", line_abort, 0);
        reset = 1'b0;
        drive(CH_START, 1'b1, CH_START, 1'b1);
        #1;
        check("t6_rr_s0_ready", s0_ready, 1);
        check("t6_rr_s1_ready", s1_ready, 0);
        step();
        check("t6_rr_src", out_src, 0);
        check("t6_rr_char", out_char, CH_START);
        check("t6_rr_no_abort", line_abort, 0);
        drive(8'h00, 1'b0, 8'h00, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
